// File: rtl/operand_fetch_pkg.sv
// rtl/operand_fetch_pkg.sv - shared pipeline constants and forward-select encoding
package operand_fetch_pkg;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;

  localparam logic [REG_AW-1:0] REG_ZERO = '0;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_WB  = 2'd1,
    FWD_MEM = 2'd2,
    FWD_EX  = 2'd3
  } fwd_sel_e;

endpackage

// File: rtl/operand_fetch_fwd_mux.sv
// rtl/operand_fetch_fwd_mux.sv - priority forward compare and 4:1 operand select
module fwd_mux #(
  parameter int DATA_W = operand_fetch_pkg::DATA_W,
  parameter int REG_AW = operand_fetch_pkg::REG_AW
) (
  input  logic [REG_AW-1:0] src,
  input  logic              ex_valid,
  input  logic              ex_reg_write,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_dest,
  input  logic [DATA_W-1:0] ex_result,
  input  logic              mem_reg_write,
  input  logic [REG_AW-1:0] mem_dest,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              wb_reg_write,
  input  logic [REG_AW-1:0] wb_dest,
  input  logic [DATA_W-1:0] wb_data,
  input  logic [DATA_W-1:0] rf_data,
  output logic [DATA_W-1:0] data
);

  import operand_fetch_pkg::*;

  logic     src_is_zero;
  fwd_sel_e sel;

  assign src_is_zero = (src == REG_AW'(REG_ZERO));

  // Youngest producer wins; a load in EX has no value yet so it is skipped here
  // and covered by the load-use stall instead. src != 0 implies dest != 0 on match.
  always_comb begin
    sel = FWD_RF;
    if (!src_is_zero) begin
      if (ex_valid && ex_reg_write && !ex_mem_read && (ex_dest == src)) begin
        sel = FWD_EX;
      end else if (mem_reg_write && (mem_dest == src)) begin
        sel = FWD_MEM;
      end else if (wb_reg_write && (wb_dest == src)) begin
        sel = FWD_WB;
      end
    end
  end

  // Register zero always reads as zero regardless of any bypass path.
  always_comb begin
    data = '0;
    if (!src_is_zero) begin
      case (sel)
        FWD_EX:  data = ex_result;
        FWD_MEM: data = mem_data;
        FWD_WB:  data = wb_data;
        default: data = rf_data;
      endcase
    end
  end

endmodule

// File: rtl/operand_fetch.sv
// rtl/operand_fetch.sv - ID/EX stage with forwarding, load-use stall and stall counter
module operand_fetch #(
  parameter int DATA_W = operand_fetch_pkg::DATA_W,
  parameter int REG_AW = operand_fetch_pkg::REG_AW,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic [REG_AW-1:0] id_dest,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [DATA_W-1:0] rf_rd1,
  input  logic [DATA_W-1:0] rf_rd2,
  input  logic [DATA_W-1:0] ex_result,
  input  logic              mem_reg_write,
  input  logic [REG_AW-1:0] mem_dest,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              wb_reg_write,
  input  logic [REG_AW-1:0] wb_dest,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              flush,
  output logic              stall,
  output logic              ex_valid,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic [REG_AW-1:0] ex_dest,
  output logic [DATA_W-1:0] ex_op_a,
  output logic [DATA_W-1:0] ex_op_b,
  output logic [DATA_W-1:0] ex_imm,
  output logic [CNT_W-1:0]  stall_count
);

  import operand_fetch_pkg::*;

  logic [DATA_W-1:0] fwd_a;
  logic [DATA_W-1:0] fwd_b;
  logic              rs_hit;
  logic              rt_hit;
  logic              ex_is_load;

  fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rs (
    .src           (id_rs),
    .ex_valid      (ex_valid),
    .ex_reg_write  (ex_reg_write),
    .ex_mem_read   (ex_mem_read),
    .ex_dest       (ex_dest),
    .ex_result     (ex_result),
    .mem_reg_write (mem_reg_write),
    .mem_dest      (mem_dest),
    .mem_data      (mem_data),
    .wb_reg_write  (wb_reg_write),
    .wb_dest       (wb_dest),
    .wb_data       (wb_data),
    .rf_data       (rf_rd1),
    .data          (fwd_a)
  );

  fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rt (
    .src           (id_rt),
    .ex_valid      (ex_valid),
    .ex_reg_write  (ex_reg_write),
    .ex_mem_read   (ex_mem_read),
    .ex_dest       (ex_dest),
    .ex_result     (ex_result),
    .mem_reg_write (mem_reg_write),
    .mem_dest      (mem_dest),
    .mem_data      (mem_data),
    .wb_reg_write  (wb_reg_write),
    .wb_dest       (wb_dest),
    .wb_data       (wb_data),
    .rf_data       (rf_rd2),
    .data          (fwd_b)
  );

  // Load-use detection looks only at registered EX state, never at ex_result,
  // so the stall path stays short.
  always_comb begin
    ex_is_load = ex_valid && ex_mem_read && ex_reg_write && (ex_dest != REG_AW'(REG_ZERO));
    rs_hit     = id_uses_rs && (id_rs == ex_dest);
    rt_hit     = id_uses_rt && (id_rt == ex_dest);
    stall      = id_valid && ex_is_load && (rs_hit || rt_hit);
  end

  // ID/EX pipeline register: reset, then flush/stall bubble, then normal capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid     <= 1'b0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_dest      <= '0;
      ex_op_a      <= '0;
      ex_op_b      <= '0;
      ex_imm       <= '0;
    end else if (flush || stall) begin
      ex_valid     <= 1'b0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_dest      <= '0;
      ex_op_a      <= '0;
      ex_op_b      <= '0;
      ex_imm       <= '0;
    end else begin
      ex_valid     <= id_valid;
      ex_reg_write <= id_valid && id_reg_write;
      ex_mem_read  <= id_valid && id_mem_read;
      ex_dest      <= id_dest;
      ex_op_a      <= fwd_a;
      ex_op_b      <= fwd_b;
      ex_imm       <= id_imm;
    end
  end

  // Saturating count of load-use stall cycles; counts even when a flush coincides.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count <= '0;
    end else if (stall && (stall_count != {CNT_W{1'b1}})) begin
      stall_count <= stall_count + 1'b1;
    end
  end

endmodule

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
- ID/EX boundary stage of the pipelined core. Consumes the two combinational read ports of the register file and produces registered, hazard-resolved operands for EX.
- Applies forwarding from the EX, MEM and WB stages. The WB bypass is required because a register-file write lands only at the clock edge.
- Detects load-use hazards: stalls IF/ID and inserts a bubble.
- Keeps a stall performance counter.

Parameters:
- DATA_W, 32, operand/result width
- REG_AW, 5, register address width
- CNT_W, 32, stall counter width

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  IF/ID holds a real instruction
- id_rs, id_rt  in  REG_AW  source register numbers; these also drive the register-file read addresses
- id_uses_rs, id_uses_rt  in  1  operand actually consumed
- id_dest  in  REG_AW  destination register
- id_reg_write, id_mem_read  in  1  instruction writes a register / is a load
- id_imm  in  DATA_W  sign/zero-extended immediate, passed through
- rf_rd1, rf_rd2  in  DATA_W  register-file read data
- ex_result  in  DATA_W  combinational ALU result of the instruction now in EX
- mem_reg_write  in  1  write-enable of the instruction in MEM
- mem_dest  in  REG_AW  destination of the instruction in MEM
- mem_data  in  DATA_W  final value of the instruction in MEM, load data included
- wb_reg_write  in  1  write-enable of the instruction in WB
- wb_dest  in  REG_AW  destination of the instruction in WB
- wb_data  in  DATA_W  value being written to the register file this cycle
- flush  in  1  branch/jump redirect; kill the ID instruction
- stall  out  1  freeze PC and IF/ID this cycle
- ex_valid, ex_reg_write, ex_mem_read  out  1  registered control
- ex_dest  out  REG_AW  registered destination
- ex_op_a, ex_op_b, ex_imm  out  DATA_W  registered operands and immediate
- stall_count  out  CNT_W  number of load-use stall cycles since reset

Behaviour:
- Reset (rst=1 at edge): all ex_* outputs = 0, stall_count = 0. Because ex_valid = 0, stall is combinationally 0 on the first cycle after reset. rst overrides flush and stall.
- Hazard, combinational:
  - stall = id_valid & ex_valid & ex_mem_read & ex_reg_write & (ex_dest != 0) & ((id_uses_rs & id_rs == ex_dest) | (id_uses_rt & id_rt == ex_dest)).
  - stall is a registered-state function only; it never depends on ex_result.
- Forward select, per operand src (rs or rt):
  - src == 0: value 0.
  - Otherwise first match wins:
    - EX: ex_valid & ex_reg_write & !ex_mem_read & ex_dest == src, giving ex_result;
    - MEM: mem_reg_write & mem_dest == src, giving mem_data;
    - WB: wb_reg_write & wb_dest == src, giving wb_data;
    - else rf_rd1 / rf_rd2.
  - A forward is never taken from a stage whose destination is 0.
- Register update each edge, lowest-numbered case wins:
  1. rst: clear, as above.
  2. flush: ex_valid = 0, ex_reg_write = 0, ex_mem_read = 0. Data fields don't-care (implementation drives 0).
  3. stall: bubble. Same as flush, and stall_count increments.
  4. Otherwise: ex_valid = id_valid; control, dest, forwarded operands and imm are captured. If id_valid = 0, ex_reg_write and ex_mem_read are forced to 0.
- flush together with stall: the bubble is inserted and stall_count still increments. The upstream redirect discards the held IF/ID instruction.
- Latency: one cycle from the ID inputs to the ex_* outputs. A load followed by a dependent instruction costs exactly one stall cycle. On the next cycle the load is in MEM and the value is forwarded from mem_data.
- stall_count saturates at all-ones; it does not wrap.

Decomposition:
- Shared pipeline package holds:
  - DATA_W and REG_AW constants;
  - REG_ZERO = 0;
  - the forward-select enum {FWD_RF, FWD_WB, FWD_MEM, FWD_EX}.
- One sub-module, fwd_mux, instantiated twice (rs, rt): the priority compare and 4:1 select.
- Hazard logic and the pipeline register stay in the top module.

Test Plan:
- Reset: hold rst 2 cycles with id_valid=1 -> all ex_* = 0, stall = 0, stall_count = 0.
- EX forward: EX holds an ALU op with dest=5, ex_result=0x11; ID reads rs=5, rf_rd1=0x0; MEM has dest=5, data 0x22 -> next cycle ex_op_a = 0x11.
- WB bypass: wb_reg_write=1, wb_dest=9, wb_data=0xDEAD; rf_rd2 still 0 -> ex_op_b = 0xDEAD. With rt=0 and wb_dest=0 -> ex_op_b = 0.
- Load-use: lw dest=3 in EX; ID uses rt=3 -> stall=1 for one cycle, bubble (ex_valid=0), stall_count=1. Next cycle, with mem_data=0x1234, ex_op_b = 0x1234.
- Load not used: same lw, but id_uses_rt=0 -> stall = 0.
- Flush priority: flush and stall both asserted -> ex_valid = 0, stall_count increments. Separately, a flush with no hazard -> ex_valid = 0, stall_count unchanged.
